pipelined_carry_skip_adder: RTL and testbench
=============================================

Name: pipelined_carry_skip_adder

Overview:
- Parametrised, pipelined carry-skip adder with a valid/ready handshake on both sides.
- WIDTH-bit operands are split into BLOCK-bit ripple blocks, each with skip logic.
- Blocks are spread evenly across STAGES register stages; one add is accepted per cycle at full throughput.
- It is the registered, flow-controlled successor to the combinational 4-bit-block skip adder, for datapaths that need to close timing at large widths.

Parameters:
- WIDTH, default 32: operand and sum width. Must be a multiple of BLOCK.
- BLOCK, default 4: bits per ripple/skip block.
- STAGES, default 2: number of pipeline register stages (≥1). (WIDTH/BLOCK) must be divisible by STAGES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB.
- overflow  out  1  signed overflow.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: while rst_n=0, all stage valid bits, out_valid, sum, cout, overflow and all pipeline data registers are 0.
  - in_ready is 1 after reset because all stages are empty.
  - Assertion mid-operation discards all in-flight results immediately, with no output.
- Stage partitioning:
  - NBLK = WIDTH/BLOCK blocks; BPS = NBLK/STAGES blocks per stage.
  - Stage k evaluates blocks k*BPS .. k*BPS+BPS-1, using the carry registered by stage k-1 (stage 0 uses cin).
  - Stage k registers: the low partial sum computed so far, the carry out of its last block, the still-unused upper operand bits, and the carry into the MSB.
- Per-block arithmetic:
  - sum_i = a_i ^ b_i ^ c_i, with c_{i+1} = majority(a_i, b_i, c_i).
  - Block carry out = ripple carry OR (AND of all p_i = a_i^b_i within the block AND block carry in).
  - The result must be bit-identical to a + b + cin mod 2^(WIDTH+1).
- overflow = (carry into bit WIDTH-1) XOR cout.
- Latency: exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid, when there is no backpressure.
- Handshake:
  - Each stage holds a valid bit and advances when its successor is empty or advancing: ready_k = !valid_k | ready_{k+1}.
  - The last stage uses out_ready; in_ready = ready_0.
  - Combinational ready chain; no bubbles are inserted.
  - A transfer occurs on any edge where valid & ready are both 1.
- Boundary conditions:
  - out_valid=1 & out_ready=0 holds sum, cout and overflow stable. Stages fill until STAGES results are buffered, then in_ready=0.
  - Simultaneous accept and drain while full: in_ready=1 because out_ready=1, and occupancy is unchanged.
  - in_valid=0 inserts a bubble; out_valid drops accordingly.
  - Inputs not accepted have no effect.
- Ordering: results emerge strictly in acceptance order.

Optional Feature:
- Macro: PIPELINED_CSK_SUB_EN.
- When defined:
  - Extra input port sub (1 bit), sampled with the operands.
  - sub=1 computes a + ~b + 1; cin is ignored.
  - sub=0 behaves as the normal add.
  - cout keeps its carry meaning (1 means no borrow); overflow follows the same rule.
- When undefined: the sub port is absent and logic is add-only.

Decomposition:
- Package csk_pkg holds:
  - localparam-style constants NBLK and BPS, derived via functions of WIDTH/BLOCK/STAGES;
  - a typedef for the per-stage payload struct (partial sum, carry, msb_carry, remaining a/b);
  - a compile-time legality check function for the divisibility rules.
- One natural sub-module: csk_block, a combinational BLOCK-bit ripple with skip OR, instantiated NBLK times via generate.
- Stage registers and handshake live in the top module.

Test Plan (WIDTH=32, BLOCK=4, STAGES=2):
- Reset: rst_n=0 then release, no input → out_valid=0, sum=0, cout=0, overflow=0, in_ready=1.
- Full skip chain: a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 → 2 cycles later sum=0x00000000, cout=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, overflow=1. Also a=0x80000000, b=0x80000000, cin=1 → sum=0x00000001, cout=1, overflow=1.
- Backpressure: out_ready=0, present 3 back-to-back adds (1+1, 2+2, 3+3) → 2 accepted, in_ready=0 on the third. Then out_ready=1 → outputs 2, 4, 6 in order; none lost or duplicated.
- Mid-flight reset: accept 2 adds, assert rst_n=0 for 1 cycle → out_valid=0 at once, no result emerges after release.
- PIPELINED_CSK_SUB_EN: a=5, b=7, sub=1 → sum=0xFFFFFFFE, cout=0, overflow=0. Also a=7, b=5, sub=1 → sum=2, cout=1.

Source files
------------

// File: rtl/csk_pkg.sv
// ---------------------------------------------------------------------------
// csk_pkg
// Shared helpers for the pipelined carry-skip adder.
//   csk_nblk  : number of BLOCK-bit ripple/skip blocks in a WIDTH-bit adder
//   csk_bps   : blocks evaluated per pipeline stage
//   csk_legal : elaboration-time check of the WIDTH/BLOCK/STAGES divisibility rules
//   csk_ctl_t : carry bookkeeping registered by the output stage
// Optional build macro used by the top: PIPELINED_CSK_SUB_EN (adds a sub port).
// ---------------------------------------------------------------------------
package csk_pkg;

  // Carry state held alongside the partial sum. msb_carry is the carry into
  // bit WIDTH-1, kept so overflow is a single XOR at the output.
  typedef struct packed {
    logic carry;
    logic msb_carry;
  } csk_ctl_t;

  function automatic int csk_nblk(input int width, input int block);
    return width / block;
  endfunction

  function automatic int csk_bps(input int width, input int block, input int stages);
    return (width / block) / stages;
  endfunction

  function automatic bit csk_legal(input int width, input int block, input int stages);
    return (block > 0) && (stages >= 1) && (width >= block) &&
           (width % block == 0) && ((width / block) % stages == 0);
  endfunction

endpackage

// File: rtl/csk_block.sv
// ---------------------------------------------------------------------------
// csk_block
// Combinational BLOCK-bit ripple adder with carry-skip OR.
// Ports:
//   a, b : block operand slices
//   ci   : block carry in
//   s    : block sum
//   co   : block carry out (ripple carry OR (all propagate AND ci))
// ---------------------------------------------------------------------------
module csk_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);

  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end
  end

  assign s = p ^ c[BLOCK-1:0];

  // The skip term gives timing a short path from ci to co when the whole
  // block propagates; logically it never disagrees with the ripple carry.
  assign co = c[BLOCK] | ((&p) & ci);

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// ---------------------------------------------------------------------------
// pipelined_carry_skip_adder
// WIDTH-bit carry-skip adder split into BLOCK-bit blocks, spread evenly over
// STAGES register stages with valid/ready flow control on both sides.
// Result equals a + b + cin (mod 2^(WIDTH+1) including cout); latency is
// STAGES cycles with full throughput.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake
//   a, b, cin           : operands and carry in
//   sub                 : (only with PIPELINED_CSK_SUB_EN) 1 = a + ~b + 1, cin ignored
//   out_valid/out_ready : result handshake
//   sum, cout, overflow : result, carry out of MSB, signed overflow
// Build macro: PIPELINED_CSK_SUB_EN enables the subtract port.
// ---------------------------------------------------------------------------
module pipelined_carry_skip_adder
  import csk_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_CSK_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NBLK = csk_nblk(WIDTH, BLOCK);
  localparam int BPS  = csk_bps(WIDTH, BLOCK, STAGES);
  localparam int SW   = BPS * BLOCK;   // operand bits consumed per stage

  if (!csk_legal(WIDTH, BLOCK, STAGES)) begin : g_illegal
    $error("pipelined_carry_skip_adder: WIDTH/BLOCK/STAGES divisibility violated");
  end

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef PIPELINED_CSK_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  blk_sum;
  logic [WIDTH-1:0]  out_sum;
  csk_ctl_t          out_ctl;

  // ready_k = !valid_k | ready_{k+1} unrolled: a stage may load if any stage
  // at or after it is empty, or the sink is taking the head result.
  for (genvar k = 0; k < STAGES; k++) begin : g_rdy
    assign rdy[k] = out_ready | ~(&vld[STAGES-1:k]);
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int IW = WIDTH - k * SW;   // operand bits still unused on entry
    localparam int PW = (k + 1) * SW;     // partial-sum bits known on exit

    logic [IW-1:0] a_i;
    logic [IW-1:0] b_i;
    logic          c_i;
    logic          v_i;
    logic          c_n;
    logic [PW-1:0] ps_n;
    logic [PW-1:0] ps_q;
    logic          v_q;

    if (k == 0) begin : g_src
      assign a_i  = a;
      assign b_i  = b_eff;
      assign c_i  = cin_eff;
      assign v_i  = in_valid;
      assign ps_n = blk_sum[SW-1:0];
    end else begin : g_src
      assign a_i  = g_stg[k-1].g_fwd.a_q;
      assign b_i  = g_stg[k-1].g_fwd.b_q;
      assign c_i  = g_stg[k-1].g_fwd.c_q;
      assign v_i  = g_stg[k-1].v_q;
      assign ps_n = {blk_sum[PW-1:k*SW], g_stg[k-1].ps_q};
    end

    assign c_n = g_blk[k*BPS + BPS - 1].co;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        ps_q <= '0;
      end else if (rdy[k]) begin
        v_q <= v_i;
        if (v_i) ps_q <= ps_n;
      end
    end

    assign vld[k] = v_q;

    if (k < STAGES - 1) begin : g_fwd
      logic [IW-SW-1:0] a_q;
      logic [IW-SW-1:0] b_q;
      logic             c_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (rdy[k] && v_i) begin
          a_q <= a_i[IW-1:SW];
          b_q <= b_i[IW-1:SW];
          c_q <= c_n;
        end
      end
    end else begin : g_last
      csk_ctl_t ctl_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctl_q <= '0;
        end else if (rdy[k] && v_i) begin
          // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
          ctl_q <= '{carry: c_n,
                     msb_carry: a_i[IW-1] ^ b_i[IW-1] ^ blk_sum[WIDTH-1]};
        end
      end

      assign out_ctl = ctl_q;
      assign out_sum = ps_q;
    end
  end

  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    localparam int SK  = j / BPS;
    localparam int OFS = (j % BPS) * BLOCK;

    logic             ci;
    logic             co;
    logic [BLOCK-1:0] blk_a;
    logic [BLOCK-1:0] blk_b;

    if (j % BPS == 0) begin : g_ci
      assign ci = g_stg[SK].c_i;
    end else begin : g_ci
      assign ci = g_blk[j-1].co;
    end

    assign blk_a = g_stg[SK].a_i[OFS +: BLOCK];
    assign blk_b = g_stg[SK].b_i[OFS +: BLOCK];

    csk_block #(.BLOCK(BLOCK)) u_blk (
      .a  (blk_a),
      .b  (blk_b),
      .ci (ci),
      .s  (blk_sum[j*BLOCK +: BLOCK]),
      .co (co)
    );
  end

  assign out_valid = vld[STAGES-1];
  assign sum       = out_sum;
  assign cout      = out_ctl.carry;
  assign overflow  = out_ctl.carry ^ out_ctl.msb_carry;

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
module tb_pipelined_carry_skip_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
`ifdef PIPELINED_CSK_SUB_EN
  logic        sub = 1'b0;
`endif

  always #5 clk = ~clk;

  pipelined_carry_skip_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPELINED_CSK_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tv[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                         input logic vs, input logic [31:0] es, input logic eco,
                         input logic eov);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sub = vs; v.s = es; v.co = eco; v.ov = eov;
    tv.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
`ifdef PIPELINED_CSK_SUB_EN
    sub      = v.sub;
`endif
    in_valid = 1'b1;
  endtask

  task automatic drive_add(input logic [31:0] va, input logic [31:0] vb);
    a        = va;
    b        = vb;
    cin      = 1'b0;
`ifdef PIPELINED_CSK_SUB_EN
    sub      = 1'b0;
`endif
    in_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got_q[$];
    int          late;

    //          a             b             cin sub  sum           cout ovf
    add_vec(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0);
    add_vec(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1);
    add_vec(32'h8000_0000, 32'h8000_0000, 1, 0, 32'h0000_0001, 1, 1);
    add_vec(32'h0000_0000, 32'h0000_0000, 0, 0, 32'h0000_0000, 0, 0);
    add_vec(32'h0000_0000, 32'h0000_0000, 1, 0, 32'h0000_0001, 0, 0);
    add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 1, 0);
    add_vec(32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 32'hACF1_3568, 0, 0);
    add_vec(32'h0000_FFFF, 32'h0000_0001, 0, 0, 32'h0001_0000, 0, 0);
    add_vec(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h7FFF_FFFF, 1, 1);
    add_vec(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1, 0, 32'h0000_0000, 1, 0);
    add_vec(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 0, 32'hFFFF_FFFF, 0, 1);
`ifdef PIPELINED_CSK_SUB_EN
    add_vec(32'h0000_0005, 32'h0000_0007, 0, 1, 32'hFFFF_FFFE, 0, 0);
    add_vec(32'h0000_0007, 32'h0000_0005, 0, 1, 32'h0000_0002, 1, 0);
    add_vec(32'h0000_0007, 32'h0000_0005, 1, 1, 32'h0000_0002, 1, 0);
    add_vec(32'h8000_0000, 32'h0000_0001, 0, 1, 32'h7FFF_FFFF, 1, 1);
`endif

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.out_valid", out_valid, 0);
    check("rst.sum", sum, 0);
    check("rst.cout", cout, 0);
    check("rst.overflow", overflow, 0);
    check("rst.in_ready", in_ready, 1);

    // Isolated vectors: latency and values
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d.lat", i), out_valid, 0);
      @(negedge clk);
      check($sformatf("v%0d.valid", i), out_valid, 1);
      check($sformatf("v%0d.sum", i), sum, tv[i].s);
      check($sformatf("v%0d.cout", i), cout, tv[i].co);
      check($sformatf("v%0d.ovf", i), overflow, tv[i].ov);
      @(negedge clk);
    end

    // Same vectors back-to-back at full throughput
    for (int i = 0; i < tv.size() + 2; i++) begin
      if (i >= 2) begin
        check($sformatf("s%0d.valid", i - 2), out_valid, 1);
        check($sformatf("s%0d.sum", i - 2), sum, tv[i-2].s);
        check($sformatf("s%0d.cout", i - 2), cout, tv[i-2].co);
        check($sformatf("s%0d.ovf", i - 2), overflow, tv[i-2].ov);
      end else begin
        check($sformatf("s%0d.fill", i), out_valid, 0);
      end
      if (i < tv.size()) drive(tv[i]);
      else in_valid = 1'b0;
      @(negedge clk);
    end
    check("stream.drained", out_valid, 0);

    // Backpressure: two buffered, third stalls, then drains in order
    out_ready = 1'b0;
    drive_add(32'd1, 32'd1);
    #1 check("bp.rdy0", in_ready, 1);
    @(negedge clk);
    drive_add(32'd2, 32'd2);
    #1 check("bp.rdy1", in_ready, 1);
    @(negedge clk);
    drive_add(32'd3, 32'd3);
    #1 check("bp.rdy2", in_ready, 0);
    check("bp.hold_valid", out_valid, 1);
    check("bp.hold_sum", sum, 32'd2);
    repeat (2) @(negedge clk);
    check("bp.stall_rdy", in_ready, 0);
    check("bp.stable_sum", sum, 32'd2);
    out_ready = 1'b1;
    #1 check("bp.drain_rdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    got_q.push_back(32'd0);
    got_q.delete();
    // The first head result (2) transferred on the edge just taken.
    got_q.push_back(32'd2);
    for (int c = 0; c < 6; c++) begin
      if (out_valid) got_q.push_back(sum);
      @(negedge clk);
    end
    check("bp.count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("bp.out1", got_q[1], 32'd4);
      check("bp.out2", got_q[2], 32'd6);
    end

    // Mid-flight reset discards everything
    out_ready = 1'b0;
    drive_add(32'd10, 32'd10);
    @(negedge clk);
    drive_add(32'd20, 32'd20);
    @(negedge clk);
    in_valid = 1'b0;
    check("mr.full", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mr.valid_now", out_valid, 0);
    check("mr.sum_now", sum, 0);
    check("mr.rdy_now", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    late = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) late++;
    end
    check("mr.no_result", late, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
